spi_csr_bridge: RTL and testbench
=================================

SPI_CSR_BRIDGE -- requirements
Module: spi_csr_bridge

Interface
REQ-001 Parameter ADDR_W, default 5, CSR address width, legal 1..7.
REQ-002 Parameter CPOL, default 0, SCK idle level.
REQ-003 Parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter AUTO_INC, default 1; 1 = address increments per data byte, 0 = address fixed.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 sck, nss, sdi  input  1 each  SPI pins, asynchronous to clk.
REQ-008 sdo_o  output  1  serial data out; sdo_oe  output  1  drive enable, high only while nss is low.
REQ-009 chip_select  output  1  high while a transaction is open.
REQ-010 csr_address  output  ADDR_W  CSR address.
REQ-011 csr_read, csr_write  output  1 each  single-cycle strobes.
REQ-012 csr_writedata  output  8  write data; csr_readdata  input  8  valid exactly 1 clk after csr_read.

Function
REQ-013 sck, nss and sdi SHALL each pass through a 2-FF synchronizer; sck edges SHALL be detected from the synchronized value.
REQ-014 The sample edge SHALL be derived from CPOL/CPHA per mode 0..3; the shift edge is the opposite edge.
REQ-015 clk SHALL be at least 8x the SCK frequency; behaviour below this ratio is undefined.
REQ-016 The FSM SHALL have four states: IDLE, CMD, WR, RD.
REQ-017 Synchronized nss falling SHALL move the FSM IDLE->CMD, clear the bit counter and raise chip_select on the same cycle.
REQ-018 Bits SHALL be sampled MSB first; the byte completes on the 8th sample edge.
REQ-019 Command byte: bit7 = 1 for write, 0 for read; bits[ADDR_W-1:0] = start address; intermediate bits are ignored.
REQ-020 On command completion, the FSM SHALL move CMD->WR or CMD->RD and load csr_address.
REQ-021 On entering RD, csr_read SHALL pulse on the cycle after command completion (prefetch).
REQ-022 csr_readdata SHALL be captured into the TX shift register 1 clk after csr_read.
REQ-023 WR: on each completed data byte, csr_writedata SHALL take the byte and csr_write SHALL pulse 1 clk after completion.
REQ-024 RD: on each completed data byte, csr_read SHALL pulse for the next address 1 clk after completion, prefetching the following byte.
REQ-025 If AUTO_INC=1, csr_address SHALL increment after each data-byte strobe, modulo 2^ADDR_W (wrap to 0).
REQ-026 sdo_o SHALL present TX shift register bit7 and shift on each shift edge.
REQ-027 During CMD and WR, sdo_o SHALL shift out 0x00.
REQ-028 With CPHA=0, bit7 SHALL be valid before the first sample edge.
REQ-029 Synchronized nss rising in any state SHALL return the FSM to IDLE, discard the partial byte and drop chip_select.
REQ-030 A pending strobe for an already-completed byte SHALL still issue.
REQ-031 The last prefetched read data SHALL be discarded.
REQ-032 csr_read and csr_write SHALL never be asserted in the same cycle.

Reset
REQ-033 While reset is high, the FSM SHALL be IDLE; chip_select, csr_read, csr_write and sdo_oe = 0; csr_address and csr_writedata = 0; shift registers and synchronizers = 0 (sck synchronizer = CPOL).
REQ-034 Reset asserted mid-transaction SHALL abort it with no strobe.
REQ-035 After reset release, a new transaction SHALL start only on a fresh nss falling edge.

Verification
REQ-036 Mode 0, write 0x83,0xAA,0x55 -> csr_write pulses with addr 3/0xAA then addr 4/0x55; no csr_read.
REQ-037 Mode 3, read 0x1F + 2 dummy bytes, readdata = addr+0x10 -> MISO bytes 0x2F,0x10 (address wraps 31->0); csr_read pulses 3 times.
REQ-038 AUTO_INC=0, write 0x82 + 3 bytes -> all 3 strobes at addr 2.
REQ-039 nss rises after 5 data bits of a write byte -> no csr_write for that byte; FSM IDLE; chip_select = 0.
REQ-040 reset pulsed mid read byte -> all outputs at reset values; next transaction completes correctly.
REQ-041 Mode 1 and mode 2 write/read loopback at an 8:1 clk:sck ratio -> data bit-exact.

Source files
------------

// File: rtl/spi_csr_bridge.sv
// SPI slave for modes 0..3 that turns a command byte plus data bytes into
// single-cycle CSR read/write strobes, with read prefetch and optional address auto-increment.
module spi_csr_bridge #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned CPOL     = 0,
  parameter int unsigned CPHA     = 0,
  parameter int unsigned AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              nss,
  input  logic              sdi,
  output logic              sdo_o,
  output logic              sdo_oe,
  output logic              chip_select,
  output logic [ADDR_W-1:0] csr_address,
  output logic              csr_read,
  output logic              csr_write,
  output logic [7:0]        csr_writedata,
  input  logic [7:0]        csr_readdata
);

  localparam logic SCK_IDLE    = 1'(CPOL);
  localparam logic SAMPLE_RISE = (CPOL == CPHA);

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  logic sck_m, sck_s, sck_d;
  logic nss_m, nss_s, nss_d;
  logic sdi_m, sdi_s;

  // Two-stage synchronizers; the third sck/nss stage only serves edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_m <= SCK_IDLE;
      sck_s <= SCK_IDLE;
      sck_d <= SCK_IDLE;
      nss_m <= 1'b0;
      nss_s <= 1'b0;
      nss_d <= 1'b0;
      sdi_m <= 1'b0;
      sdi_s <= 1'b0;
    end else begin
      sck_m <= sck;
      sck_s <= sck_m;
      sck_d <= sck_s;
      nss_m <= nss;
      nss_s <= nss_m;
      nss_d <= nss_s;
      sdi_m <= sdi;
      sdi_s <= sdi_m;
    end
  end

  logic sck_rise, sck_fall, sample_edge, shift_edge, nss_fall, nss_rise;

  assign sck_rise    = sck_s & ~sck_d;
  assign sck_fall    = ~sck_s & sck_d;
  assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
  assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;
  assign nss_fall    = ~nss_s & nss_d;
  assign nss_rise    = nss_s & ~nss_d;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [7:0] tx_sr;
  logic       rd_capture;
  logic [7:0] rx_byte;
  logic       byte_done;

  assign rx_byte   = {rx_sr, sdi_s};
  assign byte_done = sample_edge && (bit_cnt == 3'd7);
  assign sdo_o     = tx_sr[7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= 3'd0;
      rx_sr         <= 7'd0;
      tx_sr         <= 8'd0;
      rd_capture    <= 1'b0;
      chip_select   <= 1'b0;
      sdo_oe        <= 1'b0;
      csr_address   <= '0;
      csr_read      <= 1'b0;
      csr_write     <= 1'b0;
      csr_writedata <= 8'd0;
    end else begin
      csr_read   <= 1'b0;
      csr_write  <= 1'b0;
      rd_capture <= csr_read;

      // Advance the address once the strobe for the current one has gone out.
      if (AUTO_INC != 0 && (csr_read || csr_write))
        csr_address <= csr_address + ADDR_W'(1);

      if (state == IDLE) begin
        if (nss_fall) begin
          state       <= CMD;
          bit_cnt     <= 3'd0;
          rx_sr       <= 7'd0;
          tx_sr       <= 8'd0;
          chip_select <= 1'b1;
          sdo_oe      <= 1'b1;
        end
      end else begin
        if (sample_edge) begin
          rx_sr   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end

        // No shift on the byte-boundary shift edge: bit7 of the new byte is already in place.
        if (shift_edge && bit_cnt != 3'd0)
          tx_sr <= {tx_sr[6:0], 1'b0};

        if (rd_capture && state == RD)
          tx_sr <= csr_readdata;

        if (byte_done) begin
          if (state == CMD) begin
            csr_address <= rx_byte[ADDR_W-1:0];
            if (rx_byte[7]) begin
              state <= WR;
            end else begin
              state    <= RD;
              csr_read <= 1'b1;
            end
          end else if (state == WR) begin
            csr_writedata <= rx_byte;
            csr_write     <= 1'b1;
          end else begin
            csr_read <= 1'b1;
          end
        end

        // Deselect wins over everything except a strobe already earned by a full byte.
        if (nss_rise) begin
          state       <= IDLE;
          bit_cnt     <= 3'd0;
          chip_select <= 1'b0;
          sdo_oe      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_csr_bridge.sv
// Directed bench: five bridge instances (modes 0..3 plus mode 0 without auto-increment)
// driven by a bit-banged SPI master at an 8:1 clk:sck ratio.
module tb_spi_csr_bridge;

  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] sck;
  logic [4:0] nss;
  logic       sdi;
  wire  [4:0] sdo;
  wire  [4:0] oe;
  wire  [4:0] cs;

  int tests = 0;
  int fails = 0;

  logic [7:0] mosi [8];
  logic [7:0] miso [8];

  always #5 clk = ~clk;

  // Instance g: 0=mode0, 1=mode1, 2=mode2, 3=mode3, 4=mode0 fixed address.
  for (genvar g = 0; g < 5; g++) begin : u
    logic [4:0] addr;
    logic       rd;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] rdata = 8'h00;
    logic [7:0] mem [32];
    logic [4:0] wa [8];
    logic [7:0] wd [8];
    logic [4:0] ra [8];
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         both_cnt = 0;

    spi_csr_bridge #(
      .ADDR_W  (5),
      .CPOL    ((g == 2 || g == 3) ? 1 : 0),
      .CPHA    ((g == 1 || g == 3) ? 1 : 0),
      .AUTO_INC((g == 4) ? 0 : 1)
    ) dut (
      .clk          (clk),
      .reset        (reset),
      .sck          (sck[g]),
      .nss          (nss[g]),
      .sdi          (sdi),
      .sdo_o        (sdo[g]),
      .sdo_oe       (oe[g]),
      .chip_select  (cs[g]),
      .csr_address  (addr),
      .csr_read     (rd),
      .csr_write    (wr),
      .csr_writedata(wdata),
      .csr_readdata (rdata)
    );

    // CSR target model: instance 3 returns addr+0x10, the rest are plain memories.
    always @(posedge clk) begin
      if (wr) begin
        mem[addr]          <= wdata;
        wa[3'(wr_cnt)]     <= addr;
        wd[3'(wr_cnt)]     <= wdata;
        wr_cnt             <= wr_cnt + 1;
      end
      if (rd) begin
        rdata          <= (g == 3) ? (8'(addr) + 8'h10) : mem[addr];
        ra[3'(rd_cnt)] <= addr;
        rd_cnt         <= rd_cnt + 1;
      end
      if (rd && wr)
        both_cnt <= both_cnt + 1;
    end
  end

  function automatic logic cpol_of(input int g);
    return (g == 2 || g == 3);
  endfunction

  function automatic logic cpha_of(input int g);
    return (g == 1 || g == 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic spi_bit(input int g, input logic b, output logic m);
    if (!cpha_of(g)) begin
      sdi = b;
      #HALF;
      m = sdo[g];
      sck[g] = ~cpol_of(g);
      #HALF;
      sck[g] = cpol_of(g);
    end else begin
      sck[g] = ~cpol_of(g);
      sdi = b;
      #HALF;
      m = sdo[g];
      sck[g] = cpol_of(g);
      #HALF;
    end
  endtask

  task automatic spi_byte(input int g, input logic [7:0] mo, output logic [7:0] mi);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(g, mo[i], m);
      mi[i] = m;
    end
  endtask

  task automatic sel_low(input int g);
    nss[g] = 1'b0;
    #(2 * HALF);
  endtask

  task automatic sel_high(input int g);
    #HALF;
    nss[g] = 1'b1;
    #(4 * HALF);
  endtask

  task automatic xact(input int g, input int n);
    logic [7:0] r;
    sel_low(g);
    for (int k = 0; k < n; k++) begin
      spi_byte(g, mosi[k], r);
      miso[k] = r;
    end
    sel_high(g);
  endtask

  initial begin
    int         w0, r0;
    logic [2:0] b;
    logic [7:0] r;
    logic       m;

    reset = 1'b1;
    sck   = 5'b01100;
    nss   = 5'b11111;
    sdi   = 1'b0;
    #20;

    check("reset_cs",    32'(cs[0]),       32'h0);
    check("reset_oe",    32'(oe[0]),       32'h0);
    check("reset_rd",    32'(u[0].rd),     32'h0);
    check("reset_wr",    32'(u[0].wr),     32'h0);
    check("reset_addr",  32'(u[0].addr),   32'h0);
    check("reset_wdata", 32'(u[0].wdata),  32'h0);
    check("reset_sdo",   32'(sdo[3]),      32'h0);
    reset = 1'b0;
    #(4 * HALF);

    // Mode 0 write burst with auto-increment.
    w0 = u[0].wr_cnt; r0 = u[0].rd_cnt; b = 3'(w0);
    sel_low(0);
    check("open_cs", 32'(cs[0]), 32'h1);
    check("open_oe", 32'(oe[0]), 32'h1);
    mosi[0] = 8'h83; mosi[1] = 8'hAA; mosi[2] = 8'h55;
    for (int k = 0; k < 3; k++) begin
      spi_byte(0, mosi[k], r);
      miso[k] = r;
    end
    sel_high(0);
    check("m0w_count", 32'(u[0].wr_cnt - w0), 32'd2);
    check("m0w_a0",    32'(u[0].wa[b]),        32'h3);
    check("m0w_d0",    32'(u[0].wd[b]),        32'hAA);
    check("m0w_a1",    32'(u[0].wa[b + 3'd1]), 32'h4);
    check("m0w_d1",    32'(u[0].wd[b + 3'd1]), 32'h55);
    check("m0w_noread", 32'(u[0].rd_cnt - r0), 32'd0);
    check("m0w_miso",  32'({miso[1], miso[2]}), 32'h0000);
    check("m0w_cs_end", 32'(cs[0]), 32'h0);

    // Mode 3 read with address wrap.
    w0 = u[3].wr_cnt; r0 = u[3].rd_cnt; b = 3'(r0);
    mosi[0] = 8'h1F; mosi[1] = 8'h00; mosi[2] = 8'h00;
    xact(3, 3);
    check("m3r_cmd_miso", 32'(miso[0]), 32'h00);
    check("m3r_byte0",    32'(miso[1]), 32'h2F);
    check("m3r_byte1",    32'(miso[2]), 32'h10);
    check("m3r_reads",    32'(u[3].rd_cnt - r0), 32'd3);
    check("m3r_ra0",      32'(u[3].ra[b]),        32'd31);
    check("m3r_ra1",      32'(u[3].ra[b + 3'd1]), 32'd0);
    check("m3r_ra2",      32'(u[3].ra[b + 3'd2]), 32'd1);
    check("m3r_nowrite",  32'(u[3].wr_cnt - w0),  32'd0);
    check("m3r_addr_end", 32'(u[3].addr),         32'd2);

    // Fixed-address write burst.
    w0 = u[4].wr_cnt; b = 3'(w0);
    mosi[0] = 8'h82; mosi[1] = 8'h11; mosi[2] = 8'h22; mosi[3] = 8'h33;
    xact(4, 4);
    check("fix_count", 32'(u[4].wr_cnt - w0), 32'd3);
    check("fix_a0", 32'(u[4].wa[b]),        32'h2);
    check("fix_a1", 32'(u[4].wa[b + 3'd1]), 32'h2);
    check("fix_a2", 32'(u[4].wa[b + 3'd2]), 32'h2);
    check("fix_d",  32'({u[4].wd[b], u[4].wd[b + 3'd1], u[4].wd[b + 3'd2]}), 32'h112233);

    // Deselect after 5 bits of the second data byte.
    w0 = u[0].wr_cnt; b = 3'(w0);
    sel_low(0);
    spi_byte(0, 8'h85, r);
    spi_byte(0, 8'hC3, r);
    for (int i = 0; i < 5; i++) spi_bit(0, 1'b1, m);
    sel_high(0);
    #(16 * HALF);
    check("abort_count", 32'(u[0].wr_cnt - w0), 32'd1);
    check("abort_a",     32'(u[0].wa[b]),       32'h5);
    check("abort_d",     32'(u[0].wd[b]),       32'hC3);
    check("abort_cs",    32'(cs[0]),            32'h0);
    check("abort_oe",    32'(oe[0]),            32'h0);
    w0 = u[0].wr_cnt; b = 3'(w0);
    mosi[0] = 8'h87; mosi[1] = 8'h99;
    xact(0, 2);
    check("after_abort_a", 32'({u[0].wa[b], u[0].wd[b]}), 32'h0799);
    check("after_abort_n", 32'(u[0].wr_cnt - w0), 32'd1);

    // Reset in the middle of a mode 3 read data byte.
    sel_low(3);
    spi_byte(3, 8'h01, r);
    for (int i = 0; i < 3; i++) spi_bit(3, 1'b0, m);
    r0 = u[3].rd_cnt;
    reset = 1'b1;
    #30;
    check("rst_cs",    32'(cs[3]),       32'h0);
    check("rst_oe",    32'(oe[3]),       32'h0);
    check("rst_addr",  32'(u[3].addr),   32'h0);
    check("rst_sdo",   32'(sdo[3]),      32'h0);
    check("rst_rdwr",  32'({u[3].rd, u[3].wr}), 32'h0);
    check("rst_wdata", 32'(u[3].wdata),  32'h0);
    reset = 1'b0;
    #(4 * HALF);
    check("rst_no_strobe", 32'(u[3].rd_cnt - r0), 32'd0);
    check("rst_no_restart", 32'(cs[3]), 32'h0);
    nss[3] = 1'b1;
    #(4 * HALF);
    mosi[0] = 8'h05; mosi[1] = 8'h00;
    xact(3, 2);
    check("rst_next_read", 32'(miso[1]), 32'h15);

    // Mode 1 and mode 2 write/read loopback.
    mosi[0] = 8'h8A; mosi[1] = 8'hDE; mosi[2] = 8'h5B;
    xact(1, 3);
    mosi[0] = 8'h0A; mosi[1] = 8'h00; mosi[2] = 8'h00;
    xact(1, 3);
    check("m1_loop", 32'({miso[1], miso[2]}), 32'hDE5B);
    mosi[0] = 8'h94; mosi[1] = 8'h3C; mosi[2] = 8'hA7;
    xact(2, 3);
    mosi[0] = 8'h14; mosi[1] = 8'h00; mosi[2] = 8'h00;
    xact(2, 3);
    check("m2_loop", 32'({miso[1], miso[2]}), 32'h3CA7);

    check("excl_0", 32'(u[0].both_cnt), 32'd0);
    check("excl_1", 32'(u[1].both_cnt), 32'd0);
    check("excl_2", 32'(u[2].both_cnt), 32'd0);
    check("excl_3", 32'(u[3].both_cnt), 32'd0);
    check("excl_4", 32'(u[4].both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
